idma_obi_sub_mem: RTL and testbench



---
 rtl/idma_obi_sub_mem.sv | 148 ++++++++++++++
 tb/tb_idma_obi_sub_mem.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/idma_obi_sub_mem.sv
// OBI subordinate backed by a word-addressed memory, returning in-order responses with a
// minimum latency. Define IDMA_OBI_SUB_MEM_STALL_EN to add LFSR-driven grant stalls.
module idma_obi_sub_mem #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned IdWidth     = 12,
  parameter int unsigned MemWords    = 256,
  parameter int unsigned Latency     = 1,
  parameter int unsigned NumReqOutst = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [IdWidth-1:0]     aid_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IdWidth-1:0]     rid_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(MemWords);
  localparam int unsigned CntW     = $clog2(NumReqOutst + 1);
  localparam int unsigned PtrW     = (NumReqOutst > 1) ? $clog2(NumReqOutst) : 1;
  localparam int unsigned AgeW     = $clog2(Latency + 1);

  localparam logic [CntW-1:0] MaxOutst = CntW'(NumReqOutst);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(NumReqOutst - 1);
  localparam logic [AgeW-1:0] LatAge   = AgeW'(Latency);

  logic [DataWidth-1:0] mem    [MemWords];
  logic [DataWidth-1:0] q_data [NumReqOutst];
  logic [IdWidth-1:0]   q_id   [NumReqOutst];
  logic                 q_err  [NumReqOutst];
  logic [AgeW-1:0]      q_age  [NumReqOutst];

  logic [PtrW-1:0]      head, tail;
  logic [CntW-1:0]      outst;
  logic [IdxW-1:0]      idx;
  logic                 oor;
  logic                 accept;
  logic                 retire;
  logic                 head_ok;
  logic                 stall;
  logic [DataWidth-1:0] rd_word;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign idx = addr_i[OffW +: IdxW];

  // Any address bit above the memory window flags the access as out of range.
  generate
    if (OffW + IdxW < AddrWidth) begin : g_oor
      assign oor = |addr_i[AddrWidth-1:OffW+IdxW];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

`ifdef IDMA_OBI_SUB_MEM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Handshakes: A channel transfers on req_i && gnt_o at a clock edge; R channel retires
  // the head on rvalid_o && rready_i, and the response holds steady until then.
  assign gnt_o  = req_i && !rst_i && (outst < MaxOutst) && !stall;
  assign accept = gnt_o;

  assign head_ok  = (outst != '0) && (q_age[head] >= LatAge);
  assign retire   = head_ok && rready_i;
  assign rvalid_o = head_ok;
  assign rdata_o  = head_ok ? q_data[head] : '0;
  assign rid_o    = head_ok ? q_id[head]   : '0;
  assign err_o    = head_ok ? q_err[head]  : 1'b0;
  assign busy_o   = (outst != '0);

  // Read data is captured from the pre-edge memory contents at the grant edge.
  assign rd_word = (we_i || oor) ? '0 : mem[idx];

  always_ff @(posedge clk_i) begin
    if (accept && we_i && !oor) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      outst <= '0;
      for (int i = 0; i < NumReqOutst; i++) begin
        q_data[i] <= '0;
        q_id[i]   <= '0;
        q_err[i]  <= 1'b0;
        q_age[i]  <= '0;
      end
    end else begin
      // Ages saturate at Latency; free slots age too but are overwritten on push.
      for (int i = 0; i < NumReqOutst; i++) begin
        if (q_age[i] < LatAge) begin
          q_age[i] <= q_age[i] + 1'b1;
        end
      end
      if (accept) begin
        q_data[tail] <= rd_word;
        q_id[tail]   <= aid_i;
        q_err[tail]  <= oor;
        q_age[tail]  <= AgeW'(1);
        tail         <= ptr_next(tail);
      end
      if (retire) begin
        head <= ptr_next(head);
      end
      case ({accept, retire})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

endmodule

// File: tb/tb_idma_obi_sub_mem.sv
// Directed bench for idma_obi_sub_mem: a default instance (Latency=1, 2 outstanding)
// and a Latency=3 instance with 4 outstanding.
module tb_idma_obi_sub_mem;

  logic        clk;
  logic        rst;

  logic        a_req, a_gnt, a_we, a_rvalid, a_rready, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic [11:0] a_aid, a_rid;

  logic        b_req, b_gnt, b_rvalid, b_rready, b_err, b_busy;
  logic [31:0] b_rdata;
  logic [11:0] b_aid, b_rid;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];

  idma_obi_sub_mem u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .we_i(a_we),
    .be_i(a_be), .wdata_i(a_wdata), .aid_i(a_aid), .rvalid_o(a_rvalid), .rready_i(a_rready),
    .rdata_o(a_rdata), .rid_o(a_rid), .err_o(a_err), .busy_o(a_busy)
  );

  idma_obi_sub_mem #(.Latency(3), .NumReqOutst(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt), .addr_i(32'h0), .we_i(1'b0),
    .be_i(4'hF), .wdata_i(32'h0), .aid_i(b_aid), .rvalid_o(b_rvalid), .rready_i(b_rready),
    .rdata_o(b_rdata), .rid_o(b_rid), .err_o(b_err), .busy_o(b_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: present a request, hold it until granted, release after the grant edge
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [11:0] aid);
    int n = 0;
    @(negedge clk);
    a_req = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wdata; a_aid = aid;
    #1;
    while (!a_gnt && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!a_gnt) check("gnt_timeout", 64'(a_gnt), 64'd1);
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  // checks the head response one cycle after the grant edge, then lets it retire
  task automatic expect_resp(input string tag, input logic [31:0] data, input logic [11:0] id,
                             input logic err);
    check({tag, "_rvalid"}, 64'(a_rvalid), 64'd1);
    check({tag, "_rdata"},  64'(a_rdata),  64'(data));
    check({tag, "_rid"},    64'(a_rid),    64'(id));
    check({tag, "_err"},    64'(a_err),    64'(err));
    @(posedge clk); #1;
  endtask

  int          exp_rv  [6] = '{0, 0, 1, 1, 1, 0};
  logic [11:0] exp_rid [6] = '{12'd0, 12'd0, 12'd1, 12'd2, 12'd3, 12'd0};

  initial begin
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0; a_be = 4'hF; a_wdata = 32'h0; a_aid = 12'h0;
    a_rready = 1'b1; b_req = 1'b0; b_aid = 12'h0; b_rready = 1'b1;

    // reset state, with a request pending that must not be granted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",    64'(a_gnt),    64'd0);
    check("rst_rvalid", 64'(a_rvalid), 64'd0);
    check("rst_rdata",  64'(a_rdata),  64'd0);
    check("rst_rid",    64'(a_rid),    64'd0);
    check("rst_err",    64'(a_err),    64'd0);
    check("rst_busy",   64'(a_busy),   64'd0);
    a_req = 1'b0;
    rst = 1'b0;

    // full write then read back, response one cycle after grant
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 12'd3);
    check("wr_busy", 64'(a_busy), 64'd1);
    expect_resp("wr_full", 32'h0, 12'd3, 1'b0);
    check("idle_busy", 64'(a_busy), 64'd0);
    issue(1'b0, 32'h10, 4'hF, 32'h0, 12'd4);
    expect_resp("rd_full", 32'hDEADBEEF, 12'd4, 1'b0);

    // partial write and an all-zero byte enable no-op write
    issue(1'b1, 32'h10, 4'b0101, 32'h11223344, 12'd5);
    expect_resp("wr_part", 32'h0, 12'd5, 1'b0);
    issue(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 12'd6);
    expect_resp("wr_be0", 32'h0, 12'd6, 1'b0);
    issue(1'b0, 32'h13, 4'hF, 32'h0, 12'd7);
    expect_resp("rd_part", 32'hDE22BE44, 12'd7, 1'b0);

    // out-of-range accesses must not alias onto word 0
    issue(1'b1, 32'h0, 4'hF, 32'h01234567, 12'd1);
    expect_resp("wr_w0", 32'h0, 12'd1, 1'b0);
    issue(1'b0, 32'h400, 4'hF, 32'h0, 12'd2);
    expect_resp("rd_oor", 32'h0, 12'd2, 1'b1);
    issue(1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 12'd3);
    expect_resp("wr_oor", 32'h0, 12'd3, 1'b1);
    issue(1'b0, 32'h0, 4'hF, 32'h0, 12'd4);
    expect_resp("rd_w0", 32'h01234567, 12'd4, 1'b0);

    // backpressure: two grants fill the queue, the third waits until a retire
    a_rready = 1'b0;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_aid = 12'd7;
    #1 check("full_gnt0", 64'(a_gnt), 64'd1);
    exp_q.push_back(12'd7);
    @(posedge clk); #1;
    a_addr = 32'h0; a_aid = 12'd8;
    #1 check("full_gnt1", 64'(a_gnt), 64'd1);
    exp_q.push_back(12'd8);
    @(posedge clk); #1;
    a_addr = 32'h10; a_aid = 12'd9;
    #1 check("full_gnt2", 64'(a_gnt), 64'd0);
    check("full_busy", 64'(a_busy), 64'd1);
    exp_q.push_back(12'd9);
    repeat (2) begin
      @(negedge clk);
      check("hold_gnt",   64'(a_gnt),    64'd0);
      check("hold_rid",   64'(a_rid),    64'(exp_q[0]));
      check("hold_rdata", 64'(a_rdata),  64'h00000000DE22BE44);
    end
    a_rready = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    check("retire_gnt",  64'(a_gnt),   64'd1);
    check("order_rid1",  64'(a_rid),   64'(exp_q[0]));
    check("order_data1", 64'(a_rdata), 64'h0000000001234567);
    @(posedge clk); #1;
    a_req = 1'b0;
    void'(exp_q.pop_front());
    check("order_rv2",   64'(a_rvalid), 64'd1);
    check("order_rid2",  64'(a_rid),    64'(exp_q[0]));
    check("order_data2", 64'(a_rdata),  64'h00000000DE22BE44);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    check("drain_busy",  64'(a_busy),   64'd0);
    check("drain_rv",    64'(a_rvalid), 64'd0);

    // Latency=3 instance: back-to-back reads, response 3 cycles after each grant
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b_req = (i < 3);
      b_aid = 12'(i + 1);
      #1;
      if (i < 3) check("l3_gnt", 64'(b_gnt), 64'd1);
      @(posedge clk); #1;
      check("l3_rvalid", 64'(b_rvalid), 64'(exp_rv[i]));
      if (exp_rv[i] != 0) check("l3_rid", 64'(b_rid), 64'(exp_rid[i]));
    end
    b_req = 1'b0;
    check("l3_busy", 64'(b_busy), 64'd0);

    // reset with two responses pending drops both
    a_rready = 1'b0;
    issue(1'b0, 32'h10, 4'hF, 32'h0, 12'd10);
    issue(1'b0, 32'h0, 4'hF, 32'h0, 12'd11);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_rvalid", 64'(a_rvalid), 64'd0);
    check("rst_mid_busy",   64'(a_busy),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    a_rready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rvalid", 64'(a_rvalid), 64'd0);
    end

`ifdef IDMA_OBI_SUB_MEM_STALL_EN
    begin
      logic [19:0] pat [2];
      for (int r = 0; r < 2; r++) begin
        @(negedge clk);
        rst = 1'b1; a_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0; a_aid = 12'd0;
        for (int c = 0; c < 20; c++) begin
          #1 pat[r][c] = a_gnt;
          @(negedge clk);
        end
        a_req = 1'b0;
      end
      check("stall_pattern", 64'(pat[1]), 64'(pat[0]));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
